pwm_decoder: RTL and testbench
==============================

# pwm_decoder

- Measures an incoming PWM waveform: period and high time, counted in `clk` cycles.
- Reports one result per PWM period through a registered `valid` strobe.
- Lets the Arduino-VGA tile capture externally generated PWM, or loop back its own `pwm_out` for self-test. It is the receive counterpart of the tile's PWM generator.
- Signals a timeout when the line stops toggling, so a stuck line never hangs the decoder.

## Interface
Parameters:
- `WIDTH`, default 8: width of the period and high-time counters and results. Longest measurable period is 2^WIDTH-1 cycles.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  measurement enable; low forces IDLE and suppresses `valid`
- `pwm_in`  in  1  asynchronous PWM input
- `period`  out  WIDTH  cycles between consecutive rising edges; 0 on timeout
- `high_time`  out  WIDTH  cycles the line was high within that period; 0 on timeout
- `valid`  out  1  one-cycle strobe; `period`, `high_time`, `timeout` and `level` are updated together with it
- `timeout`  out  1  qualifies the current result as a timeout
- `level`  out  1  synchronized line level captured with the result

## Operation
- **Input conditioning:**
  - 2-flop synchronizer produces `pwm_s`.
  - `pwm_d` holds `pwm_s` delayed by one cycle.
  - `rise = pwm_s & ~pwm_d`.
- **State machine**, with states IDLE and MEASURE:
  - IDLE: wait for `rise`. On `rise` go to MEASURE with `total_cnt` = 1 and `high_cnt` = 1.
  - MEASURE, in priority order each cycle:
    1. `!en`: go to IDLE with no report.
    2. `rise`: report `period` = `total_cnt`, `high_time` = `high_cnt`, `timeout` = 0, `level` = 1. Restart with `total_cnt` = 1 and `high_cnt` = 1. Stay in MEASURE.
    3. `total_cnt` == 2^WIDTH-1: report `period` = 0, `high_time` = 0, `timeout` = 1, `level` = `pwm_s`. Go to IDLE.
    4. Otherwise: `total_cnt` += 1; `high_cnt` += 1 when `pwm_s` is high.
- `high_cnt` ≤ `total_cnt` always holds, so `high_time` ≤ `period`.
- The first `rise` after reset, after `en` rises, or after a timeout only arms the decoder. The first report comes on the second `rise`.
- `en` low in IDLE: stay in IDLE and ignore `rise`.
- Minimum decodable period is 2 cycles (1 high, 1 low at `pwm_s`). Shorter pulses may be missed without error.
- Counters never wrap. The timeout check precedes increment, and counters are not compared against the result registers.

## Timing
- **Reset values:** `period` = 0, `high_time` = 0, `valid` = 0, `timeout` = 0, `level` = 0. State = IDLE, both counters = 0, synchronizer and `pwm_d` = 0.
- **Latency:** a `pwm_in` edge first sampled at clock edge E0 produces `rise` during the cycle after E1. Results and `valid` are registered at E2, i.e. 2 cycles from the sampling edge.
- **Result hold:** results stay stable until the next `valid`. `valid` is high for exactly one cycle.
- **Same-cycle conflict:** when `rise` and the timeout condition occur together, `rise` wins. A period of exactly 2^WIDTH-1 is reported normally; a period of 2^WIDTH or more times out.
- **Reset mid-measurement:** asynchronously clears everything. No `valid` is produced for the interrupted period.

## Configuration
- `PWM_DECODER_GLITCH_FILTER_EN` defined:
  - A 3-sample majority filter sits after the synchronizer, and its output becomes `pwm_s`.
  - Single-cycle glitches are rejected.
  - Input-to-`valid` latency becomes 4 cycles.
  - Effective minimum pulse width becomes 2 cycles, so minimum period is 4.
- Undefined: no filter, behaviour as described above.

## Structure
- **Package `pwm_decoder_pkg`:**
  - state enum (`ST_IDLE`, `ST_MEASURE`)
  - default `WIDTH` constant
  - timeout-threshold function `2**w-1`
- **Sub-module `pwm_input_conditioner`:** synchronizer, optional glitch filter and edge detector. Outputs `pwm_s` and `rise`.
- **Top module:** FSM, counters and result registers.

## Test plan
- `WIDTH`=8, steady PWM with 10-cycle period, 3 cycles high. No `valid` on the first rise; then every 10 cycles `valid` with `period`=10, `high_time`=3, `timeout`=0.
- Rise, then line held low for 300 cycles. One `valid` with `timeout`=1, `period`=0, `high_time`=0, `level`=0, then silence until two further rises.
- Boundary periods: 255-cycle period reports `period`=255; 256-cycle period reports a timeout with `level` equal to the line state.
- Minimum period: 1 high + 1 low, repeated. Reports `period`=2, `high_time`=1 (requires `PWM_DECODER_GLITCH_FILTER_EN` undefined).
- Reset: `rst` asserted mid-period clears all outputs immediately. `en` dropped mid-period gives no report, and the decoder re-arms on the first rise after `en` returns.
- Glitch: a 1-cycle high pulse inside a 20-cycle low phase.
  - With `PWM_DECODER_GLITCH_FILTER_EN`: the pulse is ignored.
  - Without it: a spurious report (e.g. `period` < 20) is produced.

Source files
------------

// File: rtl/pwm_decoder_pkg.sv
// Shared types and constants for the PWM decoder: FSM state encoding,
// default counter width and the counter saturation threshold.
package pwm_decoder_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Largest count a WIDTH-bit counter reaches before the line is declared stuck.
    function automatic int unsigned timeout_threshold(input int unsigned w);
        return (2 ** w) - 1;
    endfunction

endpackage

// File: rtl/pwm_input_conditioner.sv
// Brings the asynchronous PWM line into the clk domain and flags rising edges.
// PWM_DECODER_GLITCH_FILTER_EN inserts a 3-sample majority filter before edge detection.
module pwm_input_conditioner (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic pwm_d_q;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;
    logic filt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
            pwm_d_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            // Two of three consecutive samples must agree, so a lone sample is dropped.
            filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
            pwm_d_q <= filt_q;
        end
    end

    assign pwm_s = filt_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pwm_d_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            pwm_d_q <= sync2_q;
        end
    end

    assign pwm_s = sync2_q;
`endif

    assign rise = pwm_s & ~pwm_d_q;

endmodule

// File: rtl/pwm_decoder.sv
// Measures PWM period and high time in clk cycles, one registered report per period.
// Build option PWM_DECODER_GLITCH_FILTER_EN enables the input majority filter.
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(timeout_threshold(WIDTH));
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic pwm_s;
    logic rise;

    state_e           state_q;
    logic [WIDTH-1:0] total_cnt_q;
    logic [WIDTH-1:0] high_cnt_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_time_q;
    logic             valid_q;
    logic             timeout_q;
    logic             level_q;

    pwm_input_conditioner u_cond (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .pwm_s  (pwm_s),
        .rise   (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            total_cnt_q <= '0;
            high_cnt_q  <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en && rise) begin
                        state_q     <= ST_MEASURE;
                        total_cnt_q <= CNT_ONE;
                        high_cnt_q  <= CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                    end else if (rise) begin
                        // A rise on the saturation cycle still counts as a valid period.
                        period_q    <= total_cnt_q;
                        high_time_q <= high_cnt_q;
                        timeout_q   <= 1'b0;
                        level_q     <= 1'b1;
                        valid_q     <= 1'b1;
                        total_cnt_q <= CNT_ONE;
                        high_cnt_q  <= CNT_ONE;
                    end else if (total_cnt_q == CNT_MAX) begin
                        period_q    <= '0;
                        high_time_q <= '0;
                        timeout_q   <= 1'b1;
                        level_q     <= pwm_s;
                        valid_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        total_cnt_q <= total_cnt_q + CNT_ONE;
                        if (pwm_s) begin
                            high_cnt_q <= high_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder (WIDTH=8): reports are collected by a monitor
// and compared against hand-computed period/high-time/timeout values.
module tb_pwm_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic       pwm_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       valid;
    logic       timeout;
    logic       level;

    typedef struct {
        int p;
        int h;
        int t;
        int l;
        int c;
    } rep_t;

    rep_t rep_q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   rise_cyc;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    pwm_decoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            rep_q.push_back('{p: int'(period), h: int'(high_time), t: int'(timeout),
                              l: int'(level), c: cyc});
            $display("report: cyc=%0d period=%0d high_time=%0d timeout=%0d level=%0d",
                     cyc, period, high_time, timeout, level);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            pwm_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_reports(input string tag, input int n, input int p, input int h,
                                  input int t, input int l);
        check({tag, "_count"}, rep_q.size(), n);
        foreach (rep_q[i]) begin
            check({tag, "_period"}, rep_q[i].p, p);
            check({tag, "_high"}, rep_q[i].h, h);
            check({tag, "_timeout"}, rep_q[i].t, t);
            check({tag, "_level"}, rep_q[i].l, l);
        end
    endtask

    task automatic park();
        en = 1'b0;
        drive(1'b0, 5);
        rep_q.delete();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rise_cyc = 0;
        rst      = 1'b1;
        en       = 1'b0;
        pwm_in   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_high", int'(high_time), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_level", int'(level), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 3);

        // Steady 10-cycle PWM, 3 high: six rises give five reports.
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) rise_cyc = cyc;
            drive(1'b1, 3);
            drive(1'b0, 7);
        end
        drive(1'b0, 3);
        expect_reports("steady", 5, 10, 3, 0, 1);
        if (rep_q.size() > 0) check("latency", rep_q[0].c - rise_cyc, LAT);
        rep_q.delete();

        // Line stuck low after the last rise.
        drive(1'b0, 300);
        expect_reports("stuck_low", 1, 0, 0, 1, 0);
        rep_q.delete();
        drive(1'b1, 3);
        drive(1'b0, 7);
        check("rearm_silent", rep_q.size(), 0);
        drive(1'b1, 3);
        drive(1'b0, 3);
        expect_reports("rearm", 1, 10, 3, 0, 1);
        park();

        // Longest reportable period.
        en = 1'b1;
        drive(1'b1, 5);
        drive(1'b0, 250);
        drive(1'b1, 5);
        drive(1'b0, 250);
        drive(1'b1, 5);
        drive(1'b0, 3);
        expect_reports("p255", 2, 255, 5, 0, 1);
        park();

        // One cycle longer times out each period.
        en = 1'b1;
        drive(1'b1, 5);
        drive(1'b0, 251);
        drive(1'b1, 5);
        drive(1'b0, 256);
        expect_reports("p256", 2, 0, 0, 1, 0);
        park();

        // Stuck high: timeout reports level 1.
        en = 1'b1;
        drive(1'b1, 300);
        expect_reports("stuck_high", 1, 0, 0, 1, 1);
        park();

`ifndef PWM_DECODER_GLITCH_FILTER_EN
        // Minimum period: 1 high, 1 low.
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 3);
        expect_reports("pmin", 9, 2, 1, 0, 1);
        park();
`endif

        // en dropped mid-period: P1 reports, P2 re-arms, P3..P5 report.
        for (int i = 0; i < 60; i++) begin
            en = !(i >= 14 && i < 17);
            pwm_in = ((i % 10) < 3);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 3);
        expect_reports("en_drop", 4, 10, 3, 0, 1);
        park();

        // 1-cycle glitch inside a 20-cycle low phase.
        en = 1'b1;
        drive(1'b1, 3);
        drive(1'b0, 10);
        drive(1'b1, 1);
        drive(1'b0, 9);
        drive(1'b1, 3);
        drive(1'b0, 3);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
        check("glitch_count", rep_q.size(), 1);
        if (rep_q.size() > 0) check("glitch_period", rep_q[0].p, 23);
`else
        check("glitch_count", rep_q.size(), 2);
        if (rep_q.size() > 0) check("glitch_period", rep_q[0].p, 13);
        if (rep_q.size() > 0) check("glitch_high", rep_q[0].h, 3);
`endif
        park();

        // Asynchronous reset mid-period clears outputs without a clock edge.
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3);
            drive(1'b0, 7);
        end
        drive(1'b1, 3);
        drive(1'b0, 2);
        check("pre_rst_period", int'(period), 10);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_period", int'(period), 0);
        check("async_rst_high", int'(high_time), 0);
        check("async_rst_timeout", int'(timeout), 0);
        check("async_rst_level", int'(level), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rep_q.delete();
        drive(1'b0, 20);
        check("post_rst_silent", rep_q.size(), 0);
        en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
